// File: rtl/fir_host_driver_pkg.sv
// Shared types and constants for the FIR host driver and its coefficient bank.
package fir_host_driver_pkg;

   localparam int DATA_W           = 8;
   localparam int COEF_AW          = 4;
   localparam int COEF_DEPTH       = 16;
   localparam int DEF_DONE_TIMEOUT = 255;

   // Overflow codes reported by the filter and forwarded on res_ovf
   localparam logic [1:0] OVF_NONE = 2'b00;
   localparam logic [1:0] OVF_POS  = 2'b01;
   localparam logic [1:0] OVF_NEG  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      CFG_HDR,
      CFG_COEF,
      WAIT_SMP,
      ISSUE,
      BUSY,
      RESULT
   } state_t;

endpackage

// File: rtl/fir_host_driver_coef_bank.sv
// Coefficient register file: one write port from the host, one indexed read
// port used while streaming a configuration frame.
module fir_coef_bank
   import fir_host_driver_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [COEF_AW-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [COEF_AW-1:0] raddr,
   output logic [DATA_W-1:0]  rdata
);

   logic [COEF_DEPTH-1:0][DATA_W-1:0] mem;

   // Host write at the clock edge; whole bank clears on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  mem        <= '0;
      else if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_host_driver.sv
// Host-side driver for a FIR filter: sends configuration frames (header +
// coefficients), feeds one sample at a time and returns each result with
// overflow bookkeeping and a done-timeout watchdog.
module fir_host_driver
   import fir_host_driver_pkg::*;
#(
   parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT,
   parameter int NUM_COEF     = COEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [7:0]        cfg_wdata,
   input  logic [3:0]        cfg_taps,
   input  logic              cfg_start,
   output logic              cfg_busy,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              res_valid,
   output logic [7:0]        res_data,
   output logic [1:0]        res_ovf,
   input  logic              res_ready,
   output logic [7:0]        fir_data_in,
   output logic              fir_enable,
   output logic              fir_configuration,
   output logic              fir_config_data_enable,
   input  logic [7:0]        fir_data_out,
   input  logic [1:0]        fir_overflow_flag,
   input  logic              fir_done,
   output logic [7:0]        pos_ovf_cnt,
   output logic [7:0]        neg_ovf_cnt,
   output logic              timeout_err
);

   state_t     state, state_nx;
   logic       configured;
   logic [3:0] taps_q;
   logic [7:0] smp_q;
   logic [3:0] cidx;
   logic [7:0] tmr;
   logic       done_q;
   logic       done_rise;
   logic [7:0] coef_rd;
   logic       start_cfg, smp_acc, res_acc, tmo, last_coef;

   assign done_rise = fir_done & ~done_q;
   assign last_coef = (cidx == 4'(NUM_COEF - 1));

   fir_coef_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cfg_we & ~cfg_busy),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (cidx),
      .rdata (coef_rd)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and all strobes decoded from the current state
   always_comb begin
      state_nx               = state;
      cfg_busy               = 1'b0;
      s_ready                = 1'b0;
      res_valid              = 1'b0;
      fir_enable             = 1'b0;
      fir_configuration      = 1'b0;
      fir_config_data_enable = 1'b0;
      fir_data_in            = '0;
      start_cfg              = 1'b0;
      smp_acc                = 1'b0;
      res_acc                = 1'b0;
      tmo                    = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               start_cfg = 1'b1;
               state_nx  = CFG_HDR;
            end else if (configured) begin
               state_nx  = WAIT_SMP;
            end
         end
         CFG_HDR: begin
            cfg_busy               = 1'b1;
            fir_configuration      = 1'b1;
            fir_config_data_enable = 1'b1;
            fir_data_in            = {4'b0, taps_q};
            state_nx               = CFG_COEF;
         end
         CFG_COEF: begin
            cfg_busy               = 1'b1;
            fir_config_data_enable = 1'b1;
            fir_data_in            = coef_rd;
            if (last_coef) state_nx = WAIT_SMP;
         end
         WAIT_SMP: begin
            // a config request beats a sample offered in the same cycle
            if (cfg_start) begin
               start_cfg = 1'b1;
               state_nx  = CFG_HDR;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  smp_acc  = 1'b1;
                  state_nx = ISSUE;
               end
            end
         end
         ISSUE: begin
            fir_enable  = 1'b1;
            fir_data_in = smp_q;
            state_nx    = BUSY;
         end
         BUSY: begin
            if (done_rise) begin
               state_nx = RESULT;
            end else if (tmr == 8'(DONE_TIMEOUT - 1)) begin
               tmo      = 1'b1;
               state_nx = WAIT_SMP;
            end
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               res_acc  = 1'b1;
               state_nx = WAIT_SMP;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: latched taps/sample, frame index, busy timer, done edge, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taps_q   <= '0;
         smp_q    <= '0;
         cidx     <= '0;
         tmr      <= '0;
         done_q   <= 1'b0;
         res_data <= '0;
         res_ovf  <= OVF_NONE;
      end else begin
         done_q <= fir_done;
         if (start_cfg)                     taps_q <= cfg_taps;
         if (start_cfg)                     cidx   <= '0;
         else if (state == CFG_COEF)        cidx   <= cidx + 4'd1;
         if (smp_acc)                       smp_q  <= s_data;
         if (state == ISSUE)                tmr    <= '0;
         else if (state == BUSY)            tmr    <= tmr + 8'd1;
         if (state == BUSY && done_rise) begin
            res_data <= fir_data_out;
            res_ovf  <= fir_overflow_flag;
         end
      end
   end

   // Status: configured flag, sticky timeout and saturating overflow counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         configured  <= 1'b0;
         timeout_err <= 1'b0;
         pos_ovf_cnt <= '0;
         neg_ovf_cnt <= '0;
      end else begin
         if (state == CFG_COEF && last_coef) configured  <= 1'b1;
         if (tmo)                            timeout_err <= 1'b1;
         if (res_acc && res_ovf == OVF_POS && pos_ovf_cnt != 8'hFF)
            pos_ovf_cnt <= pos_ovf_cnt + 8'd1;
         if (res_acc && res_ovf == OVF_NEG && neg_ovf_cnt != 8'hFF)
            neg_ovf_cnt <= neg_ovf_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_fir_host_driver.sv
// Directed-plus-random bench for fir_host_driver with a behavioural FIR
// stand-in driven from the main sequence.
module tb_fir_host_driver;
   import fir_host_driver_pkg::*;

   localparam int DT = 20;
   localparam int NC = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [7:0] cfg_wdata = '0;
   logic [3:0] cfg_taps = '0;
   logic       cfg_start = 1'b0;
   logic       cfg_busy;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_ready;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] res_ovf;
   logic       res_ready = 1'b0;
   logic [7:0] fir_data_in;
   logic       fir_enable, fir_configuration, fir_config_data_enable;
   logic [7:0] fir_data_out = '0;
   logic [1:0] fir_overflow_flag = '0;
   logic       fir_done = 1'b0;
   logic [7:0] pos_ovf_cnt, neg_ovf_cnt;
   logic       timeout_err;

   fir_host_driver #(.DONE_TIMEOUT(DT), .NUM_COEF(NC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_taps(cfg_taps), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
      .res_ready(res_ready),
      .fir_data_in(fir_data_in), .fir_enable(fir_enable),
      .fir_configuration(fir_configuration),
      .fir_config_data_enable(fir_config_data_enable),
      .fir_data_out(fir_data_out), .fir_overflow_flag(fir_overflow_flag),
      .fir_done(fir_done),
      .pos_ovf_cnt(pos_ovf_cnt), .neg_ovf_cnt(neg_ovf_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] bank_m [NC];
   int         pos_m = 0;
   int         neg_m = 0;
   logic       to_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic strobes_idle(input string tag);
      chk({tag, "_cde"},  fir_config_data_enable, 0);
      chk({tag, "_cfg"},  fir_configuration, 0);
      chk({tag, "_en"},   fir_enable, 0);
      chk({tag, "_din"},  fir_data_in, 0);
      chk({tag, "_busy"}, cfg_busy, 0);
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      bank_m[a] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Sends a frame and checks every beat against the bank model. abort_at>=0
   // pulls reset at that beat and returns with rst_n still low.
   task automatic run_frame(input logic [3:0] taps, input int abort_at, input bit with_smp);
      logic [7:0] exp;
      @(negedge clk);
      cfg_start = 1'b1; cfg_taps = taps;
      if (with_smp) begin
         s_valid = 1'b1; s_data = 8'h77;
         #1 chk("collide_s_ready", s_ready, 0);
      end
      @(posedge clk);
      for (int i = 0; i <= NC; i++) begin
         @(negedge clk);
         cfg_start = 1'b0; s_valid = 1'b0;
         cfg_taps = 4'($urandom);
         if (i == 2) begin
            cfg_we = 1'b1; cfg_addr = 4'd15; cfg_wdata = ~bank_m[15];
         end else cfg_we = 1'b0;
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1 strobes_idle("abort");
            for (int k = 0; k < NC; k++) bank_m[k] = 8'h00;
            pos_m = 0; neg_m = 0; to_m = 1'b0;
            return;
         end
         exp = (i == 0) ? {4'b0, taps} : bank_m[i-1];
         chk("frame_cde",  fir_config_data_enable, 1);
         chk("frame_cfg",  fir_configuration, (i == 0) ? 1 : 0);
         chk("frame_data", fir_data_in, exp);
         chk("frame_busy", cfg_busy, 1);
         chk("frame_en",   fir_enable, 0);
      end
      @(negedge clk);
      chk("frame_end_cde",  fir_config_data_enable, 0);
      chk("frame_end_busy", cfg_busy, 0);
      chk("frame_end_rdy",  s_ready, 1);
      chk("frame_end_en",   fir_enable, 0);
   endtask

   // One sample through the filter model: done rises dly cycles into BUSY,
   // result is held off for hold cycles before being accepted.
   task automatic sample(input logic [7:0] d, input logic [7:0] r, input logic [1:0] ovf,
                         input int dly, input int hold);
      @(negedge clk);
      s_valid = 1'b1; s_data = d;
      #1 chk("smp_ready", s_ready, 1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0; s_data = 8'($urandom);
      chk("issue_en",   fir_enable, 1);
      chk("issue_data", fir_data_in, d);
      chk("issue_rdy",  s_ready, 0);
      repeat (dly) begin
         @(negedge clk);
         chk("busy_res_valid", res_valid, 0);
      end
      fir_done = 1'b1; fir_data_out = r; fir_overflow_flag = ovf;
      @(negedge clk);
      fir_done = 1'b0; fir_data_out = 8'($urandom); fir_overflow_flag = 2'($urandom);
      chk("res_valid", res_valid, 1);
      chk("res_data",  res_data, r);
      chk("res_ovf",   res_ovf, ovf);
      chk("res_s_rdy", s_ready, 0);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_data",  res_data, r);
         chk("hold_s_rdy", s_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (ovf == OVF_POS) pos_m = (pos_m < 255) ? pos_m + 1 : 255;
      if (ovf == OVF_NEG) neg_m = (neg_m < 255) ? neg_m + 1 : 255;
      chk("post_s_rdy", s_ready, 1);
      chk("post_valid", res_valid, 0);
      chk("pos_cnt", pos_ovf_cnt, pos_m);
      chk("neg_cnt", neg_ovf_cnt, neg_m);
      chk("to_err",  timeout_err, to_m);
   endtask

   initial begin
      for (int k = 0; k < NC; k++) bank_m[k] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_ovf", res_ovf, 0);
      chk("rst_pos", pos_ovf_cnt, 0);
      chk("rst_neg", neg_ovf_cnt, 0);
      chk("rst_to", timeout_err, 0);
      strobes_idle("rst");
      rst_n = 1'b1;

      // unconfigured: samples are refused
      s_valid = 1'b1; s_data = 8'h55;
      repeat (4) begin
         @(negedge clk);
         chk("unconf_ready", s_ready, 0);
         chk("unconf_en", fir_enable, 0);
      end
      s_valid = 1'b0;

      // directed frame h_k = k+1, taps = 7, then the directed sample
      for (int k = 0; k < NC; k++) write_coef(4'(k), 8'(k + 1));
      run_frame(4'd7, -1, 1'b0);
      sample(8'h20, 8'h11, OVF_NONE, 5, 0);
      sample(8'($urandom), 8'($urandom), OVF_NONE, 3, 10);

      // overflow saturation
      for (int n = 0; n < 300; n++)
         sample(8'($urandom), 8'($urandom), OVF_POS, 1 + int'($urandom_range(0, 2)),
                int'($urandom_range(0, 1)));
      chk("pos_sat", pos_ovf_cnt, 255);
      sample(8'($urandom), 8'($urandom), OVF_NEG, 2, 0);
      chk("neg_one", neg_ovf_cnt, 1);

      // random coefficient rewrite from idle, new frame
      for (int k = 0; k < 6; k++) write_coef(4'($urandom), 8'($urandom));
      run_frame(4'($urandom), -1, 1'b0);
      sample(8'($urandom), 8'($urandom), OVF_NONE, int'($urandom_range(1, 8)), 2);

      // timeout: done never rises
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      chk("to_issue_en", fir_enable, 1);
      for (int k = 1; k <= DT + 1; k++) begin
         @(negedge clk);
         chk("to_res_valid", res_valid, 0);
         if (k == DT) chk("to_early", timeout_err, 0);
         if (k == DT + 1) begin
            chk("to_set", timeout_err, 1);
            chk("to_wait_rdy", s_ready, 1);
         end
      end
      to_m = 1'b1;
      sample(8'($urandom), 8'($urandom), OVF_NEG, 4, 0);

      // collision: cfg_start beats s_valid; sample not consumed
      run_frame(4'd3, -1, 1'b1);
      sample(8'($urandom), 8'($urandom), OVF_POS, 2, 1);

      // reset mid-frame at coefficient 5
      run_frame(4'($urandom), 6, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rrst_to", timeout_err, 0);
      chk("rrst_pos", pos_ovf_cnt, 0);
      chk("rrst_neg", neg_ovf_cnt, 0);
      s_valid = 1'b1; s_data = 8'h99;
      repeat (5) begin
         @(negedge clk);
         chk("rrst_ready", s_ready, 0);
         strobes_idle("rrst");
      end
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) write_coef(4'($urandom), 8'($urandom));
      run_frame(4'($urandom), -1, 1'b0);
      sample(8'($urandom), 8'($urandom), OVF_POS, 3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
